// File: rtl/frame_serializer_n_m_pkg.sv
// Shared types for the frame serializer.
package frame_serializer_n_m_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;
endpackage

// File: rtl/frame_serializer_n_m_shiftbuf.sv
// m-word shift buffer: parallel load wins over shift; shifts toward word 0.
module shiftbuf_n_m #(
  parameter int n = 32,
  parameter int m = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [m-1:0][n-1:0] data_i,
  output logic [n-1:0]        word0_o
);
  logic [m-1:0][n-1:0] buf_q, buf_d, nxt;

  for (genvar k = 0; k < m; k++) begin : g_word
    if (k == m-1) begin : g_top
      assign nxt[k] = '0;
    end else begin : g_mid
      assign nxt[k] = buf_q[k+1];
    end
  end

  always_comb begin
    buf_d = buf_q;
    if (load_i)       buf_d = data_i;
    else if (shift_i) buf_d = nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) buf_q <= '0;
    else        buf_q <= buf_d;
  end

  assign word0_o = buf_q[0];
endmodule

// File: rtl/frame_serializer_n_m.sv
// Loads an m-word frame in one cycle and streams it out word 0 first over valid/ready.
module frame_serializer_n_m
  import frame_serializer_n_m_pkg::*;
#(
  parameter int n       = 32,
  parameter int address = 4,
  parameter int m       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [m-1:0][n-1:0] data_i,
  input  logic                load_i,
  input  logic                ready_i,
  output logic [n-1:0]        data_o,
  output logic                valid_o,
  output logic                last_o,
  output logic [address-1:0]  cnt_o,
  output logic                busy_o,
  output logic                fl_end_o
);
  localparam logic [address-1:0] LAST_IDX = address'(m-1);

  state_e             state_q, state_d;
  logic [address-1:0] cnt_q, cnt_d;
  logic [n-1:0]       word0;
  logic               do_load, xfer, at_last;

  assign do_load = (state_q == S_IDLE) && load_i;
  assign xfer    = (state_q == S_SEND) && ready_i;
  assign at_last = (cnt_q == LAST_IDX);

  shiftbuf_n_m #(.n(n), .m(m)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (do_load),
    .shift_i (xfer),
    .data_i  (data_i),
    .word0_o (word0)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (load_i) begin
        state_d = S_SEND;
        cnt_d   = '0;
      end
      S_SEND: if (ready_i) begin
        // cnt is cleared on the final word so it never wraps past m-1
        if (at_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + address'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_o  = (state_q == S_SEND);
    data_o   = valid_o ? word0 : '0;
    last_o   = valid_o && at_last;
    cnt_o    = cnt_q;
    busy_o   = (state_q != S_IDLE);
    fl_end_o = (state_q == S_DONE);
  end
endmodule

// File: tb/tb_frame_serializer_n_m.sv
// Randomized bench for frame_serializer_n_m (m=16 and m=1 instances).
module tb_frame_serializer_n_m;
  localparam int N = 32;
  localparam int A = 4;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [M-1:0][N-1:0] data_i;
  logic load_i = 1'b0, ready_i = 1'b0;
  logic [N-1:0] data_o;
  logic valid_o, last_o, busy_o, fl_end_o;
  logic [A-1:0] cnt_o;

  logic [0:0][N-1:0] data1_i;
  logic load1_i = 1'b0, ready1_i = 1'b0;
  logic [N-1:0] data1_o;
  logic valid1_o, last1_o, busy1_o, fl_end1_o;
  logic [0:0] cnt1_o;

  int total = 0;
  int bad = 0;

  frame_serializer_n_m #(.n(N), .address(A), .m(M)) dut (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_i), .load_i(load_i), .ready_i(ready_i),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .cnt_o(cnt_o),
    .busy_o(busy_o), .fl_end_o(fl_end_o));

  frame_serializer_n_m #(.n(N), .address(1), .m(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data1_i), .load_i(load1_i), .ready_i(ready1_i),
    .data_o(data1_o), .valid_o(valid1_o), .last_o(last1_o), .cnt_o(cnt1_o),
    .busy_o(busy1_o), .fl_end_o(fl_end1_o));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({valid_o, busy_o, fl_end_o, last_o} !== 4'b0 || data_o !== '0 || cnt_o !== '0) begin
      bad++;
      $display("FAIL %s: valid=%b busy=%b fl_end=%b last=%b data=%h cnt=%0d, required all 0",
               tag, valid_o, busy_o, fl_end_o, last_o, data_o, cnt_o);
    end
  endtask

  // mode 0: ready always 1; 1: random ready; 2: 3-cycle stall while word 5 presented
  // Model: frame is a list of words; word idx is presented until a handshake advances idx.
  task automatic run_frame(input logic [M-1:0][N-1:0] fr, input int mode, input bit noisy_load,
                           input string tag);
    int idx = 0, cyc = 0, stall = 0;
    bit rdy;
    data_i = fr; load_i = 1'b1; ready_i = 1'b0;
    step();
    load_i = 1'b0;
    while (idx < M && cyc < 400) begin
      total++;
      if (valid_o !== 1'b1 || data_o !== fr[idx] || cnt_o !== A'(idx) ||
          last_o !== (idx == M-1) || busy_o !== 1'b1 || fl_end_o !== 1'b0) begin
        bad++;
        $display("FAIL %s word%0d: valid=%b data=%h cnt=%0d last=%b busy=%b fl_end=%b, required 1 %h %0d %b 1 0",
                 tag, idx, valid_o, data_o, cnt_o, last_o, busy_o, fl_end_o, fr[idx], idx, idx == M-1);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: begin
          rdy = !(idx == 5 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      ready_i = rdy;
      if (noisy_load) begin
        load_i = $urandom_range(0, 1);
        data_i = {M{$urandom()}};
      end
      step();
      if (rdy) idx++;
      cyc++;
    end
    if (mode != 1) begin
      total++;
      if (cyc !== M + (mode == 2 ? 3 : 0)) begin
        bad++;
        $display("FAIL %s frame length: got %0d cycles, required %0d", tag, cyc, M + (mode == 2 ? 3 : 0));
      end
    end
    ready_i = $urandom_range(0, 1);
    if (noisy_load) load_i = 1'b1;
    total++;
    if (fl_end_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL %s done: fl_end=%b valid=%b busy=%b, required 1 0 1", tag, fl_end_o, valid_o, busy_o);
    end
    step();
    load_i = 1'b0;
    check_idle({tag, " idle"});
    step();
    check_idle({tag, " stays idle"});
  endtask

  function automatic logic [M-1:0][N-1:0] rand_frame();
    logic [M-1:0][N-1:0] f;
    for (int k = 0; k < M; k++) f[k] = $urandom();
    return f;
  endfunction

  task automatic test_reset();
    data_i = '0; data1_i = '0;
    rst_n = 1'b0;
    #12;
    check_idle("reset");
    total++;
    if ({valid1_o, busy1_o, fl_end1_o, last1_o} !== 4'b0 || data1_o !== '0 || cnt1_o !== 1'b0) begin
      bad++;
      $display("FAIL reset m1: valid=%b busy=%b fl_end=%b last=%b data=%h, required all 0",
               valid1_o, busy1_o, fl_end1_o, last1_o, data1_o);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [M-1:0][N-1:0] f;
    for (int k = 0; k < M; k++) f[k] = N'(32'h100 + k);
    run_frame(f, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    logic [M-1:0][N-1:0] f;
    for (int k = 0; k < M; k++) f[k] = N'(32'h100 + k);
    run_frame(f, 2, 1'b0, "bp");
    for (int r = 0; r < 3; r++) run_frame(rand_frame(), 1, 1'b0, "rand_bp");
  endtask

  task automatic test_load_ignored();
    for (int r = 0; r < 3; r++) run_frame(rand_frame(), r % 2, 1'b1, "load_ign");
  endtask

  task automatic test_reset_mid();
    logic [M-1:0][N-1:0] f;
    f = rand_frame();
    data_i = f; load_i = 1'b1; ready_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int k = 0; k < 8; k++) step();
    total++;
    if (valid_o !== 1'b1 || data_o !== f[8] || cnt_o !== A'(8)) begin
      bad++;
      $display("FAIL rst_mid pre: valid=%b data=%h cnt=%0d, required 1 %h 8", valid_o, data_o, cnt_o, f[8]);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid async");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check_idle("rst_mid after");
    end
    run_frame(rand_frame(), 0, 1'b0, "rst_mid new");
  endtask

  task automatic test_m1_back_to_back();
    logic [N-1:0] w;
    int since_end = -1;
    int frames = 0, cyc = 0;
    w = $urandom();
    data1_i[0] = w; load1_i = 1'b1; ready1_i = 1'b1;
    step();
    while (frames < 5 && cyc < 100) begin
      total++;
      if (valid1_o !== 1'b1 || last1_o !== 1'b1 || data1_o !== w || cnt1_o !== 1'b0 ||
          (frames > 0 && since_end != 2)) begin
        bad++;
        $display("FAIL m1 word f%0d: valid=%b last=%b data=%h cnt=%0d gap=%0d, required 1 1 %h 0 2",
                 frames, valid1_o, last1_o, data1_o, cnt1_o, since_end, w);
      end
      step(); cyc++;
      total++;
      if (fl_end1_o !== 1'b1 || valid1_o !== 1'b0) begin
        bad++;
        $display("FAIL m1 done f%0d: fl_end=%b valid=%b, required 1 0", frames, fl_end1_o, valid1_o);
      end
      since_end = 0;
      // New data presented now is what the idle cycle will capture
      w = $urandom(); data1_i[0] = w;
      while (valid1_o !== 1'b1 && cyc < 100) begin
        step(); cyc++; since_end++;
      end
      frames++;
    end
    load1_i = 1'b0;
    step(); step(); step();
    total++;
    if (busy1_o !== 1'b0 || valid1_o !== 1'b0) begin
      bad++;
      $display("FAIL m1 end idle: busy=%b valid=%b, required 0 0", busy1_o, valid1_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_ignored();
    test_reset_mid();
    test_m1_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
